wr_strobe_sequencer: RTL and testbench

- Parametrised write-strobe sequencer that drives the datapath register-file write port (wr_en, address, data) with programmable spacing and burst length.
- Replaces the fixed every-6-cycles wr_en generator in the top level.
- Adds a start/busy/done handshake, stop/abort, one-shot and continuous modes, and incrementing address and data.
- Sits in top between the simulation/control stimulus and Datapath.

---
 rtl/wr_seq_pkg.sv | 15 +
 rtl/strobe_gap_timer.sv | 32 +++
 rtl/wr_strobe_sequencer.sv | 149 ++++++++++++++
 tb/tb_wr_strobe_sequencer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/wr_seq_pkg.sv
// Shared definitions for the write-strobe sequencer: FSM state encoding and
// burst mode constants.
package wr_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_CONT    = 1'b1;

endpackage

// File: rtl/strobe_gap_timer.sv
// Down-counter that times the idle gap between write strobes; expire flags
// the last idle cycle (gap = 1).
module strobe_gap_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             expire
);

  logic [CNT_W-1:0] gap_q, gap_d;

  always_comb begin
    gap_d = gap_q;
    if (load) begin
      gap_d = load_val;
    end else if (dec && (gap_q != '0)) begin
      gap_d = gap_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) gap_q <= '0;
    else     gap_q <= gap_d;
  end

  assign expire = (gap_q == CNT_W'(1));

endmodule

// File: rtl/wr_strobe_sequencer.sv
// Register-file write-strobe sequencer: bursts of num_writes strobes spaced
// period+1 cycles apart, with incrementing address/data, one-shot or continuous.
module wr_strobe_sequencer
  import wr_seq_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              mode,
  input  logic [CNT_W-1:0]  period,
  input  logic [CNT_W-1:0]  num_writes,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DATA_W-1:0] data_seed,
  input  logic [DATA_W-1:0] data_step,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  wr_count
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d, count_inc;
  logic [CNT_W-1:0]  period_q, period_d, num_q, num_d;
  logic              mode_q, mode_d;
  logic [ADDR_W-1:0] base_q, base_d, cur_addr_q, cur_addr_d;
  logic [DATA_W-1:0] seed_q, seed_d, step_q, step_d, cur_data_q, cur_data_d;
  logic              tmr_load, tmr_dec, tmr_expire;
  logic [CNT_W-1:0]  tmr_val;

  strobe_gap_timer #(.CNT_W(CNT_W)) u_gap (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .expire   (tmr_expire)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    period_d   = period_q;
    num_d      = num_q;
    mode_d     = mode_q;
    base_d     = base_q;
    seed_d     = seed_q;
    step_d     = step_q;
    cur_addr_d = cur_addr_q;
    cur_data_d = cur_data_q;
    count_inc  = count_q + 1'b1;
    tmr_load   = 1'b0;
    tmr_dec    = 1'b0;
    tmr_val    = period_q;

    unique case (state_q)
      ST_IDLE: begin
        // stop outranks start, so a simultaneous pair leaves us idle
        if (start && !stop) begin
          period_d   = period;
          num_d      = num_writes;
          mode_d     = mode;
          base_d     = base_addr;
          seed_d     = data_seed;
          step_d     = data_step;
          cur_addr_d = base_addr;
          cur_data_d = data_seed;
          count_d    = '0;
          tmr_val    = period;
          if (num_writes == '0) begin
            state_d = ST_DONE;
          end else if (period == '0) begin
            state_d = ST_WRITE;
          end else begin
            state_d  = ST_WAIT;
            tmr_load = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (stop) begin
          state_d = ST_DONE;
        end else if (tmr_expire) begin
          state_d = ST_WRITE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_WRITE: begin
        count_d    = count_inc;
        cur_addr_d = cur_addr_q + 1'b1;
        cur_data_d = cur_data_q + step_q;
        if ((count_inc == num_q) && (mode_q == MODE_CONT)) begin
          count_d    = '0;
          cur_addr_d = base_q;
          cur_data_d = seed_q;
        end
        if (stop || ((count_inc == num_q) && (mode_q == MODE_ONESHOT))) begin
          state_d = ST_DONE;
        end else if (period_q == '0) begin
          state_d = ST_WRITE;
        end else begin
          state_d  = ST_WAIT;
          tmr_load = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Burst parameters and running address/data need no reset: outputs are gated by state
  always_ff @(posedge clk) begin
    period_q   <= period_d;
    num_q      <= num_d;
    mode_q     <= mode_d;
    base_q     <= base_d;
    seed_q     <= seed_d;
    step_q     <= step_d;
    cur_addr_q <= cur_addr_d;
    cur_data_q <= cur_data_d;
  end

  assign wr_en    = (state_q == ST_WRITE);
  assign busy     = (state_q == ST_WAIT) || (state_q == ST_WRITE);
  assign done     = (state_q == ST_DONE);
  assign wr_count = count_q;
  assign wr_addr  = wr_en ? cur_addr_q : '0;
  assign wr_data  = wr_en ? cur_data_q : '0;

endmodule

// File: tb/tb_wr_strobe_sequencer.sv
// Directed bench for wr_strobe_sequencer with a cycle-index model of the
// burst schedule and literal pins on the observed write/done log.
module tb_wr_strobe_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, stop, mode;
  logic [7:0]  period, num_writes;
  logic [3:0]  base_addr;
  logic [31:0] data_seed, data_step;
  logic        wr_en, busy, done;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [7:0]  wr_count;

  wr_strobe_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .period(period), .num_writes(num_writes), .base_addr(base_addr),
    .data_seed(data_seed), .data_step(data_step), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
    .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model: phase 0 idle, 1 running (cycle m_c since accept), 2 done pulse
  int          m_ph = 0, m_c = 0, m_p = 0, m_n = 0, m_hold = 0;
  bit          m_mode = 1'b0;
  logic [3:0]  m_base = '0;
  logic [31:0] m_seed = '0, m_step = '0;

  typedef struct { int c; logic [3:0] a; logic [31:0] d; } wr_t;
  wr_t wlog[$];
  int  cyc = 0, acc = 0, done_n = 0, done_c = -1, busy_n = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int per, comp;
    bit w, fin;
    if (rst) begin
      m_ph = 0; m_hold = 0;
      return;
    end
    per = m_p + 1;
    case (m_ph)
      0: if (start && !stop) begin
        m_p = int'(period); m_n = int'(num_writes); m_mode = mode;
        m_base = base_addr; m_seed = data_seed; m_step = data_step;
        m_hold = 0; m_c = 1;
        m_ph = (num_writes == 0) ? 2 : 1;
      end
      1: begin
        per  = m_p + 1;
        w    = (m_c % per) == 0;
        comp = m_c / per;
        fin  = !m_mode && w && (comp == m_n);
        if (stop || fin) begin
          m_ph   = 2;
          m_hold = m_mode ? comp % m_n : comp;
        end else begin
          m_c++;
        end
      end
      default: m_ph = 0;
    endcase
  endtask

  task automatic compare();
    int per, idx, e_cnt;
    bit e_wr;
    per   = m_p + 1;
    e_wr  = (m_ph == 1) && ((m_c % per) == 0);
    e_cnt = m_hold;
    if (m_ph == 1) e_cnt = m_mode ? ((m_c - 1) / per) % m_n : (m_c - 1) / per;
    chk("wr_en", wr_en, e_wr);
    chk("busy", busy, m_ph == 1);
    chk("done", done, m_ph == 2);
    chk("wr_count", wr_count, e_cnt);
    if (e_wr) begin
      idx = (m_c / per - 1) % m_n;
      chk("wr_addr", wr_addr, 4'(m_base + idx[3:0]));
      chk("wr_data", wr_data, m_seed + 32'(idx) * m_step);
    end
    if (wr_en) wlog.push_back('{c: cyc - acc + 1, a: wr_addr, d: wr_data});
    if (done) begin done_n++; done_c = cyc - acc + 1; end
    if (busy) busy_n++;
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      cyc++;
      model_edge();
      #1;
      compare();
    end
  endtask

  task automatic clr_log();
    wlog.delete();
    done_n = 0; done_c = -1; busy_n = 0;
  endtask

  task automatic launch(input bit md, input int p, input int n, input int b,
                        input logic [31:0] sd, input logic [31:0] st);
    clr_log();
    mode = md; period = 8'(p); num_writes = 8'(n); base_addr = 4'(b);
    data_seed = sd; data_step = st; start = 1'b1;
    acc = cyc + 1;
    tick();
    start = 1'b0;
    period = 8'd1; num_writes = 8'd9; base_addr = 4'd9; data_seed = 32'hdead; data_step = 32'h7;
  endtask

  task automatic pin_test1(input string tag);
    int ec[3] = '{6, 12, 18};
    chk({tag, "_nwr"}, wlog.size(), 3);
    for (int i = 0; i < 3 && i < wlog.size(); i++) begin
      chk({tag, "_wr_cyc"}, wlog[i].c, ec[i]);
      chk({tag, "_wr_addr"}, wlog[i].a, 2 + i);
      chk({tag, "_wr_data"}, wlog[i].d, 32'h10 + 32'(4 * i));
    end
    chk({tag, "_done_cyc"}, done_c, 19);
    chk({tag, "_count"}, wr_count, 3);
  endtask

  initial begin
    int ea[5] = '{0, 1, 0, 1, 0};
    rst = 1'b1; start = 0; stop = 0; mode = 0; period = 0; num_writes = 0;
    base_addr = 0; data_seed = 0; data_step = 0;
    tick(2);
    rst = 1'b0;
    tick(2);
    chk("reset_busy", busy, 0);
    chk("reset_count", wr_count, 0);
    chk("reset_addr", wr_addr, 0);

    // legacy 1-in-6 cadence, inputs scrambled after accept
    launch(0, 5, 3, 2, 32'h10, 32'h4);
    tick(22);
    pin_test1("t1");

    // back-to-back with address wrap
    launch(0, 0, 4, 14, 32'ha, 32'h1);
    tick(6);
    chk("t2_nwr", wlog.size(), 4);
    for (int i = 0; i < 4 && i < wlog.size(); i++) begin
      chk("t2_wr_cyc", wlog[i].c, i + 1);
      chk("t2_wr_addr", wlog[i].a, (14 + i) % 16);
    end
    chk("t2_busy_cycles", busy_n, 4);
    chk("t2_done_cyc", done_c, 5);

    // continuous mode, stop during WAIT
    launch(1, 1, 2, 0, 32'h0, 32'h1);
    tick(10);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick(4);
    chk("t3_nwr", wlog.size(), 5);
    for (int i = 0; i < 5 && i < wlog.size(); i++) begin
      chk("t3_wr_cyc", wlog[i].c, 2 * (i + 1));
      chk("t3_wr_addr", wlog[i].a, ea[i]);
    end
    chk("t3_done_cyc", done_c, 12);
    chk("t3_done_n", done_n, 1);
    chk("t3_count", wr_count, 1);

    // zero-length burst
    launch(0, 3, 0, 5, 32'h1, 32'h1);
    tick(3);
    chk("t4_nwr", wlog.size(), 0);
    chk("t4_done_cyc", done_c, 1);
    chk("t4_count", wr_count, 0);

    // asynchronous reset mid-WAIT, then a clean rerun
    launch(0, 5, 5, 0, 32'h100, 32'h10);
    tick(6);
    chk("t5_pre_count", wr_count, 1);
    #2 rst = 1'b1;
    #1;
    m_ph = 0; m_hold = 0;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_wr_en", wr_en, 0);
    chk("t5_rst_count", wr_count, 0);
    chk("t5_rst_addr", wr_addr, 0);
    chk("t5_rst_data", wr_data, 0);
    tick();
    rst = 1'b0;
    tick(3);
    chk("t5_no_done", done_n, 0);
    launch(0, 5, 3, 2, 32'h10, 32'h4);
    tick(22);
    pin_test1("t5");

    // start while busy ignored; start+stop in IDLE ignored
    launch(0, 2, 3, 5, 32'h1, 32'h2);
    start = 1'b1; period = 8'd0; num_writes = 8'd7; base_addr = 4'd9;
    tick(2);
    start = 1'b0;
    tick(10);
    chk("t6_nwr", wlog.size(), 3);
    for (int i = 0; i < 3 && i < wlog.size(); i++) begin
      chk("t6_wr_cyc", wlog[i].c, 3 * (i + 1));
      chk("t6_wr_addr", wlog[i].a, 5 + i);
      chk("t6_wr_data", wlog[i].d, 1 + 2 * i);
    end
    chk("t6_done_cyc", done_c, 10);
    clr_log();
    start = 1'b1; stop = 1'b1; period = 8'd0; num_writes = 8'd2;
    tick();
    start = 1'b0; stop = 1'b0;
    tick(4);
    chk("t6_ss_busy", busy_n, 0);
    chk("t6_ss_nwr", wlog.size(), 0);
    chk("t6_ss_count", wr_count, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
